alu4_arbiter: RTL and testbench

- Two-requester arbiter and sequencer that shares a single 4-bit ALU between independent clients.
- The ALU function is the codebase's alu4 case-style function:
  - 000 add, 001 subtract, 010 AND, 100 OR.
  - Any other select gives 0.
  - Result is 5-bit, A and B are 4-bit.
- Each requester posts an operation with a level request.
- The arbiter grants one requester, latches its operands, executes, returns a registered result with a one-cycle acknowledge, then rearms.
- Sits between the Ch07 datapath examples and any multi-client test harness.

---
 rtl/alu4_arbiter.sv | 169 ++++++++++++++++
 tb/tb_alu4_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu4_arbiter.sv
// Two-requester arbiter sharing one 4-bit ALU: grant, latch operands, execute,
// return a registered result with a one-cycle acknowledge, then rearm.
module alu4_arbiter #(
    parameter bit PRIO_INIT = 1'b0,
    parameter bit FAIR      = 1'b1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             REQ0,
    input  logic [2:0]       S0,
    input  logic [3:0]       A0,
    input  logic [3:0]       B0,
    input  logic             REQ1,
    input  logic [2:0]       S1,
    input  logic [3:0]       A1,
    input  logic [3:0]       B1,
    output logic [1:0]       GNT,
    output logic             ACK0,
    output logic             ACK1,
    output logic [4:0]       R,
    output logic             ERR,
    output logic             BUSY,
    output logic [CNT_W-1:0] CNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [4:0] alu4(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] y;
        case (s)
            3'b000:  y = {1'b0, a} + {1'b0, b};
            3'b001:  y = {1'b0, a} - {1'b0, b};
            3'b010:  y = {1'b0, a & b};
            3'b100:  y = {1'b0, a | b};
            default: y = 5'd0;
        endcase
        return y;
    endfunction

    function automatic logic sel_valid(input logic [2:0] s);
        logic v;
        case (s)
            3'b000, 3'b001, 3'b010, 3'b100: v = 1'b1;
            default:                        v = 1'b0;
        endcase
        return v;
    endfunction

    state_t           state_r, state_s;
    logic             prio_r, prio_s;
    logic             win_s;
    logic [2:0]       sel_r, sel_s;
    logic [3:0]       opa_r, opa_s, opb_r, opb_s;
    logic [1:0]       gnt_r, gnt_s;
    logic             ack0_r, ack0_s, ack1_r, ack1_s;
    logic [4:0]       res_r, res_s;
    logic             err_r, err_s;
    logic             busy_r, busy_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    // Next-state and next-output logic for the IDLE/EXEC/RESP sequencer
    always_comb begin
        state_s = state_r;
        prio_s  = prio_r;
        win_s   = 1'b0;
        sel_s   = sel_r;
        opa_s   = opa_r;
        opb_s   = opb_r;
        gnt_s   = gnt_r;
        ack0_s  = 1'b0;
        ack1_s  = 1'b0;
        res_s   = res_r;
        err_s   = err_r;
        busy_s  = busy_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (REQ0 && REQ1) begin
                    win_s = prio_r;
                end else if (REQ1) begin
                    win_s = 1'b1;
                end else begin
                    win_s = 1'b0;
                end
                if (REQ0 || REQ1) begin
                    sel_s   = win_s ? S1 : S0;
                    opa_s   = win_s ? A1 : A0;
                    opb_s   = win_s ? B1 : B0;
                    gnt_s   = win_s ? 2'b10 : 2'b01;
                    busy_s  = 1'b1;
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                res_s   = alu4(sel_r, opa_r, opb_r);
                err_s   = ~sel_valid(sel_r);
                ack0_s  = gnt_r[0];
                ack1_s  = gnt_r[1];
                cnt_s   = cnt_r + CNT_ONE;
                state_s = ST_RESP;
            end
            ST_RESP: begin
                gnt_s   = 2'b00;
                busy_s  = 1'b0;
                // Round-robin hands priority to the requester that was not just served
                if (FAIR) begin
                    prio_s = gnt_r[0];
                end else begin
                    prio_s = prio_r;
                end
                state_s = ST_IDLE;
            end
            default: begin
                gnt_s   = 2'b00;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched operands and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            prio_r  <= PRIO_INIT;
            sel_r   <= 3'd0;
            opa_r   <= 4'd0;
            opb_r   <= 4'd0;
            gnt_r   <= 2'b00;
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            res_r   <= 5'd0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            prio_r  <= prio_s;
            sel_r   <= sel_s;
            opa_r   <= opa_s;
            opb_r   <= opb_s;
            gnt_r   <= gnt_s;
            ack0_r  <= ack0_s;
            ack1_r  <= ack1_s;
            res_r   <= res_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
            cnt_r   <= cnt_s;
        end
    end

    assign GNT  = gnt_r;
    assign ACK0 = ack0_r;
    assign ACK1 = ack1_r;
    assign R    = res_r;
    assign ERR  = err_r;
    assign BUSY = busy_r;
    assign CNT  = cnt_r;

endmodule

// File: tb/tb_alu4_arbiter.sv
// Scoreboard bench for alu4_arbiter: a round-robin and a fixed-priority instance
// share stimulus; a transaction model predicts every acknowledge of each.
module tb_alu4_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [2:0] s0 = 3'd0, s1 = 3'd0;
    logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;

    logic [1:0] gnt_a, gnt_b;
    logic       ack0_a, ack1_a, ack0_b, ack1_b;
    logic [4:0] r_a, r_b;
    logic       err_a, err_b, busy_a, busy_b;
    logic [7:0] cnt_a, cnt_b;

    alu4_arbiter #(.PRIO_INIT(1'b0), .FAIR(1'b1), .CNT_W(8)) u_fair (
        .clk(clk), .rst(rst),
        .REQ0(req0), .S0(s0), .A0(a0), .B0(b0),
        .REQ1(req1), .S1(s1), .A1(a1), .B1(b1),
        .GNT(gnt_a), .ACK0(ack0_a), .ACK1(ack1_a), .R(r_a), .ERR(err_a),
        .BUSY(busy_a), .CNT(cnt_a)
    );

    alu4_arbiter #(.PRIO_INIT(1'b0), .FAIR(1'b0), .CNT_W(8)) u_fix (
        .clk(clk), .rst(rst),
        .REQ0(req0), .S0(s0), .A0(a0), .B0(b0),
        .REQ1(req1), .S1(s1), .A1(a1), .B1(b1),
        .GNT(gnt_b), .ACK0(ack0_b), .ACK1(ack1_b), .R(r_b), .ERR(err_b),
        .BUSY(busy_b), .CNT(cnt_b)
    );

    typedef struct {
        int who;
        int r;
        int err;
        int cnt;
        int due;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   ord_a[$];
    int   ord_b[$];
    int   busy_m[2] = '{0, 0};
    int   prio_m[2] = '{0, 0};
    int   last_m[2] = '{0, 0};
    int   cnt_m[2]  = '{0, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the operation table, using plain integer arithmetic
    task automatic alu_ref(input int s, input int a, input int b, output int r, output int e);
        e = 0;
        case (s)
            0:       r = a + b;
            1:       r = (a - b + 32) % 32;
            2:       r = a & b;
            4:       r = a | b;
            default: begin r = 0; e = 1; end
        endcase
    endtask

    // One clock of the transaction model for instance d (0 = round-robin, 1 = fixed)
    task automatic model_step(input int d);
        exp_t e;
        int   w;
        if (rst) begin
            busy_m[d] = 0;
            prio_m[d] = 0;
            cnt_m[d]  = 0;
            if (d == 0) q_a.delete(); else q_b.delete();
        end else if (busy_m[d] > 0) begin
            busy_m[d]--;
            if (busy_m[d] == 0 && d == 0) prio_m[d] = 1 - last_m[d];
        end else if (req0 || req1) begin
            w = (req0 && req1) ? prio_m[d] : (req1 ? 1 : 0);
            if (w == 1) alu_ref(int'(s1), int'(a1), int'(b1), e.r, e.err);
            else        alu_ref(int'(s0), int'(a0), int'(b0), e.r, e.err);
            cnt_m[d]  = (cnt_m[d] + 1) % 256;
            e.who     = w;
            e.cnt     = cnt_m[d];
            e.due     = cyc + 1;
            busy_m[d] = 2;
            last_m[d] = w;
            if (d == 0) q_a.push_back(e); else q_b.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step(0);
        model_step(1);
    end

    task automatic mon(input int d, input logic [1:0] g, input logic k0, input logic k1,
                       input logic [4:0] r, input logic e, input logic bz, input logic [7:0] c);
        exp_t x;
        int   n;
        check("ack_exclusive", {31'd0, k0 & k1}, 32'd0);
        check("gnt_not_11", {31'd0, g == 2'b11}, 32'd0);
        n = (d == 0) ? q_a.size() : q_b.size();
        if (k0 || k1) begin
            if (n == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack dut%0d: got ack0=%0b ack1=%0b expected none", d, k0, k1);
            end else begin
                x = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                check("ack_who", {31'd0, k1}, x.who);
                check("ack_latency", cyc, x.due);
                check("result_r", {27'd0, r}, x.r);
                check("result_err", {31'd0, e}, x.err);
                check("cnt", {24'd0, c}, x.cnt);
                check("gnt_owner", {30'd0, g}, (x.who == 1) ? 2 : 1);
                check("busy_in_resp", {31'd0, bz}, 1);
                if (d == 0) ord_a.push_back(x.who); else ord_b.push_back(x.who);
            end
        end else if (n > 0) begin
            x = (d == 0) ? q_a[0] : q_b[0];
            if (x.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_ack dut%0d: got no ack expected ack%0d at cycle %0d", d, x.who, x.due);
                if (d == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            mon(0, gnt_a, ack0_a, ack1_a, r_a, err_a, busy_a, cnt_a);
            mon(1, gnt_b, ack0_b, ack1_b, r_b, err_b, busy_b, cnt_b);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int who);
        bit got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if ((who == 0 && ack0_a) || (who == 1 && ack1_a)) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack%0d expected one within 12 cycles", who);
        end
    endtask

    task automatic set_ops(input int who, input int s, input int a, input int b);
        if (who == 0) begin s0 = 3'(s); a0 = 4'(a); b0 = 4'(b); req0 = 1'b1; end
        else          begin s1 = 3'(s); a1 = 4'(a); b1 = 4'(b); req1 = 1'b1; end
    endtask

    task automatic do_op(input int who, input int s, input int a, input int b);
        @(negedge clk);
        set_ops(who, s, a, b);
        wait_ack(who);
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    // Operands are scrambled and REQ dropped right after the grant edge
    task automatic do_op_change(input int who, input int s, input int a, input int b);
        @(negedge clk);
        set_ops(who, s, a, b);
        @(negedge clk);
        check("gnt_after_req", {30'd0, gnt_a}, (who == 1) ? 2 : 1);
        if (who == 0) begin a0 = 4'($urandom); b0 = 4'($urandom); s0 = 3'($urandom); req0 = 1'b0; end
        else          begin a1 = 4'($urandom); b1 = 4'($urandom); s1 = 3'($urandom); req1 = 1'b0; end
        wait_ack(who);
    endtask

    task automatic do_both();
        bit g0 = 1'b0, g1 = 1'b0;
        @(negedge clk);
        set_ops(0, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        set_ops(1, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        for (int i = 0; i < 20 && !(g0 && g1); i++) begin
            @(negedge clk);
            if (ack0_a) begin req0 = 1'b0; g0 = 1'b1; end
            if (ack1_a) begin req1 = 1'b0; g1 = 1'b1; end
        end
        if (!(g0 && g1)) begin
            checks++;
            errors++;
            $display("FAIL both_timeout: got ack0=%0b ack1=%0b expected both", g0, g1);
            req0 = 1'b0; req1 = 1'b0;
        end
    endtask

    initial begin
        do_reset();
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_gnt", {30'd0, gnt_a}, 0);
        check("rst_ack", {30'd0, ack0_a, ack1_a}, 0);
        check("rst_r", {27'd0, r_a}, 0);
        check("rst_err_busy", {30'd0, err_a, busy_a}, 0);
        check("rst_cnt", {24'd0, cnt_a}, 0);
        check("rst_fix_all", {gnt_b, ack0_b, ack1_b, r_b, err_b, busy_b, cnt_b}, 0);

        do_op(0, 0, 9, 8);
        check("t1_r", {27'd0, r_a}, 17);
        check("t1_cnt", {24'd0, cnt_a}, 1);
        do_op(1, 1, 3, 5);
        check("t2_sub_r", {27'd0, r_a}, 30);
        do_op(1, 2, 12, 10);
        do_op(1, 4, 12, 10);
        check("t2_or_r", {27'd0, r_a}, 14);

        do_reset();
        ord_a.delete();
        ord_b.delete();
        @(negedge clk);
        set_ops(0, 0, 5, 6);
        set_ops(1, 1, 2, 7);
        repeat (12) @(posedge clk);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        repeat (8) @(negedge clk);
        check("t3_rr_count", {31'd0, ord_a.size() >= 4}, 1);
        check("t3_fix_count", {31'd0, ord_b.size() >= 4}, 1);
        if (ord_a.size() >= 4 && ord_b.size() >= 4) begin
            check("t3_rr_order", {28'd0, ord_a[0][0], ord_a[1][0], ord_a[2][0], ord_a[3][0]}, 4'b0101);
            check("t3_fix_order", {28'd0, ord_b[0][0], ord_b[1][0], ord_b[2][0], ord_b[3][0]}, 4'b0000);
        end

        do_op(0, 3, 15, 15);
        check("t4_err", {31'd0, err_a}, 1);
        check("t4_r_zero", {27'd0, r_a}, 0);
        do_op(0, 0, 1, 2);
        check("t4_err_clear", {31'd0, err_a}, 0);

        do_reset();
        @(negedge clk);
        set_ops(1, 0, 6, 7);
        @(negedge clk);
        check("t5_gnt", {30'd0, gnt_a}, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_abort", {gnt_a, ack1_a, r_a, cnt_a}, 0);
        wait_ack(1);
        req1 = 1'b0;
        check("t5_regrant_r", {27'd0, r_a}, 13);

        do_op_change(0, 0, 7, 6);
        check("t6_latched_r", {27'd0, r_a}, 13);

        do_reset();
        for (int i = 0; i < 256; i++) do_op(0, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
        check("t6_wrap_fair", {24'd0, cnt_a}, 0);
        check("t6_wrap_fix", {24'd0, cnt_b}, 0);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0:       do_op(0, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
                1:       do_op(1, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
                2:       do_both();
                default: do_op_change($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
            endcase
        end

        repeat (10) @(negedge clk);
        check("queues_drained", q_a.size() + q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
